alu_16: RTL and testbench

- 16-bit combinational ALU with zero (z), overflow (v) and negative (n) flags, used as the datapath execute unit.
- Result and flags are combinational from alu_op, alu_a and alu_b.
- A clocked status register captures the flags on request, so later instructions can read them.
- Operation codes come from the shared `ALU_* defines (`ALU_ADD, `ALU_SUB, `ALU_AND, `ALU_OR, `ALU_XOR, `ALU_NOT, `ALU_SHL, `ALU_SHR).

---
 rtl/alu_16.sv | 146 ++++++++++++++
 tb/tb_alu_16.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_16.sv
// 16-bit execute-unit ALU: combinational result with z/v/n flags, plus a status register loaded on flag_we.
// Optional carry flag (c, c_q) is enabled by defining ALU_16_CARRY_EN.

`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif
`ifndef ALU_AND
`define ALU_AND 3'd2
`endif
`ifndef ALU_OR
`define ALU_OR 3'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'd4
`endif
`ifndef ALU_NOT
`define ALU_NOT 3'd5
`endif
`ifndef ALU_SHL
`define ALU_SHL 3'd6
`endif
`ifndef ALU_SHR
`define ALU_SHR 3'd7
`endif

module alu_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             flag_we,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             v,
  output logic             n,
`ifdef ALU_16_CARRY_EN
  output logic             c,
  output logic             c_q,
`endif
  output logic             z_q,
  output logic             v_q,
  output logic             n_q
);

  logic [3:0]       shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             z_d;
  logic             v_d;
  logic             n_d;

  assign shamt = alu_b[3:0];
  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;

  always_comb begin
    alu_out = '0;
    v       = 1'b0;
    n       = 1'b0;
    case (alu_op)
      `ALU_ADD: begin
        alu_out = sum;
        v       = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
        n       = sum[WIDTH-1];
      end
      `ALU_SUB: begin
        alu_out = diff;
        v       = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
        n       = diff[WIDTH-1];
      end
      `ALU_AND: alu_out = alu_a & alu_b;
      `ALU_OR:  alu_out = alu_a | alu_b;
      `ALU_XOR: alu_out = alu_a ^ alu_b;
      `ALU_NOT: alu_out = ~alu_a;
      `ALU_SHL: alu_out = alu_a << shamt;
      `ALU_SHR: alu_out = alu_a >> shamt;
      default:  alu_out = '0;
    endcase
    z = (alu_out == '0);
  end

`ifdef ALU_16_CARRY_EN
  // Widened copies expose the bit that falls off the end of each operation.
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [2*WIDTH-1:0] shl_ext;
  logic [2*WIDTH-1:0] shr_ext;
  logic               c_d;

  assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b};
  assign shl_ext  = {{WIDTH{1'b0}}, alu_a} << shamt;
  assign shr_ext  = {alu_a, {WIDTH{1'b0}}} >> shamt;

  always_comb begin
    c = 1'b0;
    case (alu_op)
      `ALU_ADD: c = sum_ext[WIDTH];
      `ALU_SUB: c = diff_ext[WIDTH];
      `ALU_SHL: c = shl_ext[WIDTH];
      `ALU_SHR: c = shr_ext[WIDTH-1];
      default:  c = 1'b0;
    endcase
  end

  always_comb begin
    c_d = c_q;
    if (flag_we) c_d = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_q <= 1'b0;
    else        c_q <= c_d;
  end
`endif

  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (flag_we) begin
      z_d = z;
      v_d = v;
      n_d = n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      v_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end

endmodule

// File: tb/tb_alu_16.sv
// Scoreboard bench for alu_16: a stimulus process queues hand-computed expectations,
// a monitor on the falling clock edge pops and compares result, flags and status register.

module tb_alu_16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic        rst_low;
    logic [15:0] out;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] out;
    logic        z;
    logic        v;
    logic        n;
    logic        zq;
    logic        vq;
    logic        nq;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        flag_we;
  logic [15:0] alu_out;
  logic        z, v, n;
  logic        z_q, v_q, n_q;

  int   checks;
  int   errors;
  exp_t sb[$];
  vec_t vecs[$];

  alu_16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .flag_we (flag_we),
    .alu_out (alu_out),
    .z       (z),
    .v       (v),
    .n       (n),
    .z_q     (z_q),
    .v_q     (v_q),
    .n_q     (n_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic we, input logic rst_low, input logic [15:0] out,
                         input logic ez, input logic ev, input logic en);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.we = we; t.rst_low = rst_low;
    t.out = out; t.z = ez; t.v = ev; t.n = en;
    vecs.push_back(t);
  endtask

  task automatic check_bit(input int idx, input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %b want %b", idx, name, got, want);
    end
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (alu_out !== e.out) begin
      errors++;
      $display("[TB] FAIL vec%0d alu_out: got %h want %h", e.idx, alu_out, e.out);
    end
    check_bit(e.idx, "z", z, e.z);
    check_bit(e.idx, "v", v, e.v);
    check_bit(e.idx, "n", n, e.n);
    check_bit(e.idx, "z_q", z_q, e.zq);
    check_bit(e.idx, "v_q", v_q, e.vq);
    check_bit(e.idx, "n_q", n_q, e.nq);
  endtask

  // Registered-flag model: a vector sees the flags captured by earlier vectors only.
  task automatic apply_stimulus();
    logic [2:0] reg_model;
    exp_t       e;
    reg_model = 3'b000;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      alu_op  = vecs[i].op;
      alu_a   = vecs[i].a;
      alu_b   = vecs[i].b;
      flag_we = vecs[i].we;
      rst_n   = !vecs[i].rst_low;
      if (vecs[i].rst_low) reg_model = 3'b000;
      e.idx = i;
      e.out = vecs[i].out;
      e.z   = vecs[i].z;
      e.v   = vecs[i].v;
      e.n   = vecs[i].n;
      e.zq  = reg_model[2];
      e.vq  = reg_model[1];
      e.nq  = reg_model[0];
      sb.push_back(e);
      if (vecs[i].we && !vecs[i].rst_low) reg_model = {vecs[i].z, vecs[i].v, vecs[i].n};
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0) check_output(sb.pop_front());
    end
  end

  initial begin : stimulus
    int budget;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    flag_we = 1'b0;
    alu_op  = OP_ADD;
    alu_a   = '0;
    alu_b   = '0;

    //        op      a        b        we   rst  out      z    v    n
    add_vec(OP_XOR, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
    add_vec(OP_XOR, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(OP_XOR, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    add_vec(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    add_vec(OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    add_vec(OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0);
    add_vec(OP_OR,  16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(OP_NOT, 16'h00FF, 16'h1234, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SHL, 16'h8001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SHL, 16'h0001, 16'h000F, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SHR, 16'h8000, 16'h000F, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SHR, 16'h1234, 16'hFFF0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    add_vec(OP_SUB, 16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(OP_ADD, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    add_vec(OP_SUB, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    add_vec(OP_SUB, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    add_vec(OP_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    apply_stimulus();

    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
